// File: rtl/fetch_btb.sv
// Fetch-stage PC register with a direct-mapped branch target buffer.
// Predicts the next fetch PC every cycle and is trained by branches resolving in EX.
module fetch_btb #(
  parameter int          IM_ADDR_BIT = 10,
  parameter int          BTB_IDX_BIT = 4,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pc_en,
  input  logic                   pc_ld,
  input  logic [IM_ADDR_BIT-1:0] pc_correct,
  input  logic                   upd_valid,
  input  logic [IM_ADDR_BIT-1:0] upd_pc,
  input  logic                   upd_taken,
  input  logic [IM_ADDR_BIT-1:0] upd_target,
  output logic [IM_ADDR_BIT-1:0] if_pc,
  output logic [IM_ADDR_BIT-1:0] if_pc_4,
  output logic [IM_ADDR_BIT-1:0] if_pred_pc,
  output logic                   if_pred_taken
);

  localparam int ENTRIES = 1 << BTB_IDX_BIT;
  localparam int TAG_BIT = IM_ADDR_BIT - BTB_IDX_BIT;
  localparam logic [IM_ADDR_BIT-1:0] RESET_PC_W = IM_ADDR_BIT'(RESET_PC);

  logic [IM_ADDR_BIT-1:0] pc_q, pc_d;

  logic                   valid_q  [ENTRIES];
  logic [TAG_BIT-1:0]     tag_q    [ENTRIES];
  logic [IM_ADDR_BIT-1:0] target_q [ENTRIES];
  logic [1:0]             ctr_q    [ENTRIES];

  logic [BTB_IDX_BIT-1:0] lk_idx;
  logic [TAG_BIT-1:0]     lk_tag;
  logic                   lk_hit;
  logic [IM_ADDR_BIT-1:0] pc_4;
  logic [IM_ADDR_BIT-1:0] pred_pc;
  logic                   pred_taken;

  // Lookup reads only registered state, so no input reaches an output combinationally.
  always_comb begin
    lk_idx     = pc_q[BTB_IDX_BIT-1:0];
    lk_tag     = pc_q[IM_ADDR_BIT-1:BTB_IDX_BIT];
    lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken = lk_hit && ctr_q[lk_idx][1];
    pc_4       = pc_q + IM_ADDR_BIT'(1);
    pred_pc    = pred_taken ? target_q[lk_idx] : pc_4;
  end

  always_comb begin
    pc_d = pred_pc;
    if (pc_ld) begin
      pc_d = pc_correct;
    end else if (!pc_en) begin
      pc_d = pc_q;
    end
  end

  // upd_valid is a one-cycle qualifier with no backpressure: whenever it is high,
  // upd_pc/upd_taken/upd_target are consumed at the next rising edge.
  logic [BTB_IDX_BIT-1:0] up_idx;
  logic [TAG_BIT-1:0]     up_tag;
  logic                   up_hit;
  logic                   wr_en;
  logic [IM_ADDR_BIT-1:0] target_d;
  logic [1:0]             ctr_d;

  always_comb begin
    up_idx   = upd_pc[BTB_IDX_BIT-1:0];
    up_tag   = upd_pc[IM_ADDR_BIT-1:BTB_IDX_BIT];
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    wr_en    = 1'b0;
    target_d = target_q[up_idx];
    ctr_d    = ctr_q[up_idx];
    if (upd_valid) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (upd_taken) begin
          target_d = upd_target;
          ctr_d    = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'b01;
        end else begin
          ctr_d    = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        // Allocation overwrites whatever alias occupied this index, weakly taken.
        wr_en    = 1'b1;
        target_d = upd_target;
        ctr_d    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC_W;
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else begin
      pc_q <= pc_d;
      if (wr_en) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= target_d;
        ctr_q[up_idx]    <= ctr_d;
      end
    end
  end

  assign if_pc         = pc_q;
  assign if_pc_4       = pc_4;
  assign if_pred_pc    = pred_pc;
  assign if_pred_taken = pred_taken;

endmodule

// File: tb/tb_fetch_btb.sv
// Bench for fetch_btb: directed test-plan sequence plus random traffic, checked
// against an array-based BTB model through an expected-output queue.
module tb_fetch_btb;

  localparam int AW = 10;
  localparam int NE = 16;
  localparam int PC_MOD = 1024;
  localparam int EW = 3 * AW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pc_en, pc_ld, upd_valid, upd_taken;
  logic [AW-1:0] pc_correct, upd_pc, upd_target;
  logic [AW-1:0] if_pc, if_pc_4, if_pred_pc;
  logic          if_pred_taken;

  always #5 clk = ~clk;

  fetch_btb #(.IM_ADDR_BIT(AW), .BTB_IDX_BIT(4), .RESET_PC(0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_en         (pc_en),
    .pc_ld         (pc_ld),
    .pc_correct    (pc_correct),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .if_pc         (if_pc),
    .if_pc_4       (if_pc_4),
    .if_pred_pc    (if_pred_pc),
    .if_pred_taken (if_pred_taken)
  );

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  // Reference model: fetch PC plus a table keyed by pc % NE holding pc / NE as tag.
  int m_pc;
  bit m_valid[NE];
  int m_tag[NE];
  int m_tgt[NE];
  int m_ctr[NE];

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [EW-1:0] model_outputs();
    int idx, tg, pc4, pred;
    bit hit, tk;
    idx  = m_pc % NE;
    tg   = m_pc / NE;
    pc4  = (m_pc + 1) % PC_MOD;
    hit  = m_valid[idx] && (m_tag[idx] == tg);
    tk   = hit && (m_ctr[idx] >= 2);
    pred = tk ? m_tgt[idx] : pc4;
    return {AW'(m_pc), AW'(pc4), AW'(pred), 1'(tk)};
  endfunction

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
  endtask

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("if_pc",         int'(if_pc),         int'(e[3*AW:2*AW+1]));
      chk("if_pc_4",       int'(if_pc_4),       int'(e[2*AW:AW+1]));
      chk("if_pred_pc",    int'(if_pred_pc),    int'(e[AW:1]));
      chk("if_pred_taken", int'(if_pred_taken), int'(e[0]));
    end
  end

  task automatic step(input bit en, input bit ld, input int corr,
                      input bit uv, input int upc, input bit ut, input int utgt);
    logic [EW-1:0] cur;
    int nxt, idx, tg;
    bit hit;
    @(negedge clk);
    pc_en      = en;
    pc_ld      = ld;
    pc_correct = AW'(corr);
    upd_valid  = uv;
    upd_pc     = AW'(upc);
    upd_taken  = ut;
    upd_target = AW'(utgt);
    cur = model_outputs();
    nxt = ld ? corr : (!en ? m_pc : int'(cur[AW:1]));
    @(posedge clk);
    #1;
    if (uv) begin
      idx = upc % NE;
      tg  = upc / NE;
      hit = m_valid[idx] && (m_tag[idx] == tg);
      if (hit && ut) begin
        m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
        m_tgt[idx] = utgt;
      end else if (hit) begin
        m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
      end else if (ut) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_tgt[idx]   = utgt;
        m_ctr[idx]   = 2;
      end
    end
    m_pc = nxt;
    exp_q.push_back(model_outputs());
  endtask

  // Called right after a step; asserts reset between edges and checks it before the next edge.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    model_reset();
    exp_q.push_back(model_outputs());
    chk("rst_async_pc", int'(if_pc), 0);
    chk("rst_async_tk", int'(if_pred_taken), 0);
    @(posedge clk);
    #1;
    exp_q.push_back(model_outputs());
    #1;
    rst_n = 1'b1;
  endtask

  task automatic fetch(); step(1, 0, 0, 0, 0, 0, 0); endtask
  task automatic jump(input int pc); step(1, 1, pc, 0, 0, 0, 0); endtask

  initial begin
    rst_n = 1'b0; pc_en = 1'b0; pc_ld = 1'b0; pc_correct = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    model_reset();
    @(posedge clk);
    #1;
    exp_q.push_back(model_outputs());
    #1;
    rst_n = 1'b1;

    // Sequential fetch from reset.
    repeat (3) fetch();
    chk("seq_pc", int'(if_pc), 'h003);

    // Allocation.
    step(1, 0, 0, 1, 'h005, 1, 'h040);
    jump('h005);
    chk("alloc_tk", int'(if_pred_taken), 1);
    chk("alloc_pred", int'(if_pred_pc), 'h040);
    fetch();
    chk("alloc_follow", int'(if_pc), 'h040);

    // Counter hysteresis.
    step(1, 1, 'h005, 1, 'h005, 0, 0);
    chk("hyst_nt_pred", int'(if_pred_pc), 'h006);
    repeat (3) step(1, 0, 0, 1, 'h005, 1, 'h040);
    step(1, 1, 'h005, 1, 'h005, 0, 0);
    chk("hyst_sat_pred", int'(if_pred_pc), 'h040);

    // Aliasing.
    jump('h015);
    chk("alias_miss", int'(if_pred_pc), 'h016);
    step(1, 1, 'h005, 1, 'h015, 1, 'h200);
    chk("alias_evicted", int'(if_pred_pc), 'h006);
    jump('h015);
    chk("alias_new", int'(if_pred_pc), 'h200);

    // Control priority and same-cycle training visibility.
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    chk("stall_hold", int'(if_pc), 'h015);
    step(0, 1, 'h123, 0, 0, 0, 0);
    chk("ld_over_en", int'(if_pc), 'h123);
    chk("pre_train", int'(if_pred_pc), 'h124);
    step(0, 0, 0, 1, 'h123, 1, 'h077);
    chk("post_train", int'(if_pred_pc), 'h077);

    // Wrap.
    jump('h3FF);
    chk("wrap_pc4", int'(if_pc_4), 'h000);
    fetch();
    chk("wrap_pc", int'(if_pc), 'h000);

    // Asynchronous reset mid-run, then BTB must be empty.
    mid_reset();
    repeat (3) fetch();
    chk("post_rst_pc", int'(if_pc), 'h003);
    jump('h015);
    chk("post_rst_miss", int'(if_pred_taken), 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      bit en, ld, uv, ut;
      int corr, upc, utgt;
      en   = ($urandom_range(0, 7) != 0);
      ld   = ($urandom_range(0, 9) == 0);
      corr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, PC_MOD - 1) : $urandom_range(0, 63);
      uv   = ($urandom_range(0, 2) == 0);
      upc  = ($urandom_range(0, 1) == 0) ? m_pc : $urandom_range(0, 63);
      ut   = ($urandom_range(0, 2) != 0);
      utgt = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 63) : $urandom_range(0, PC_MOD - 1);
      step(en, ld, corr, uv, upc, ut, utgt);
      if (i == 700) mid_reset();
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
